ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port RAM with a registered read port.
// One transaction in flight at a time: IDLE (grant) -> ACCESS (RAM strobe) -> RDATA (reads only).
module ram_arbiter #(
  parameter int RR = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_rd,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_gnt,
  output logic        m0_rvalid,

  input  logic        m1_req,
  input  logic        m1_rd,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_gnt,
  output logic        m1_rvalid,

  output logic [31:0] rdata,

  output logic [31:0] mem_addr,
  output logic        mem_read_signal,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_e;

  state_e      state_q, state_d;
  logic        rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic        owner_q, owner_d;   // 0 = m0, 1 = m1
  logic        last_q, last_d;     // last master served; resets to m1 so m0 wins the first tie

  logic any_req;
  logic win_m1;
  logic rr_en;

  assign rr_en   = (RR != 0);
  assign any_req = m0_req | m1_req;
  // m1 wins when alone, or on a tie when round-robin says m0 was served last.
  assign win_m1  = m1_req & (~m0_req | (rr_en & ~last_q));

  // Address and write data always reflect the latched transaction.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wmask_q <= 4'h0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rd_d            = rd_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    owner_d         = owner_q;
    last_d          = last_q;
    m0_gnt          = 1'b0;
    m1_gnt          = 1'b0;
    m0_rvalid       = 1'b0;
    m1_rvalid       = 1'b0;
    rdata           = 32'h0;
    mem_read_signal = 1'b0;
    mem_wmask       = 4'h0;

    case (state_q)
      IDLE: begin
        // Gate on reset so no grant escapes while reset is held.
        if (any_req && !reset) begin
          m0_gnt  = ~win_m1;
          m1_gnt  = win_m1;
          rd_d    = win_m1 ? m1_rd    : m0_rd;
          addr_d  = win_m1 ? m1_addr  : m0_addr;
          wdata_d = win_m1 ? m1_wdata : m0_wdata;
          wmask_d = win_m1 ? m1_wmask : m0_wmask;
          owner_d = win_m1;
          last_d  = win_m1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_read_signal = rd_q;
        mem_wmask       = rd_q ? 4'h0 : wmask_q;
        state_d         = rd_q ? RDATA : IDLE;
      end
      RDATA: begin
        rdata     = mem_rdata;
        m0_rvalid = ~owner_q;
        m1_rvalid = owner_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
